axis_pattern_gen: RTL

- Parametrised AXI-Stream master that sources a deterministic data pattern for PE and datapath test harnesses.
- Generalises the fixed one-shot sequence source:
  - selectable pattern mode and stride
  - multi-frame repeat with TLAST framing
  - software start and restart
  - correct AXIS hold-while-stalled behaviour
  - beat counter for scoreboarding
- Sits upstream of DUT AXIS slaves in lab top levels and benches.

---
 rtl/axis_pattern_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/axis_pattern_gen.sv
// AXI-Stream master sourcing a deterministic, framed data pattern (increment,
// decrement or constant) over REPEAT frames of LENGTH beats, with a run beat counter.
module axis_pattern_gen #(
  parameter int unsigned D_W          = 8,
  parameter int unsigned SEED         = 0,
  parameter int unsigned LENGTH       = 32,
  parameter int unsigned REPEAT       = 1,
  parameter int unsigned MODE         = 0,
  parameter int unsigned STRIDE       = 1,
  parameter int unsigned FRAME_RELOAD = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           m_axis_valid,
  output logic [D_W-1:0] m_axis_data,
  output logic           m_axis_last,
  input  logic           m_axis_ready,
  output logic           busy,
  output logic           done,
  output logic [31:0]    beat_cnt
);

  localparam int unsigned BEAT_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned FRAME_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [D_W-1:0]     SEED_V     = D_W'(SEED);
  localparam logic [D_W-1:0]     STRIDE_V   = D_W'(STRIDE);
  localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(LENGTH - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(REPEAT - 1);
  localparam logic               LAST_INIT  = (LENGTH == 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t               state, state_d;
  logic [BEAT_W-1:0]    beat, beat_d;
  logic [FRAME_W-1:0]   frame, frame_d;
  logic                 valid_d, last_d, busy_d, done_d;
  logic [D_W-1:0]       data_d;
  logic [31:0]          cnt_d;

  // Pattern step; wraps modulo 2^D_W.
  function automatic logic [D_W-1:0] step(input logic [D_W-1:0] d);
    case (MODE)
      0:       step = d + STRIDE_V;
      1:       step = d - STRIDE_V;
      default: step = d;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat         <= '0;
      frame        <= '0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      beat_cnt     <= '0;
    end else begin
      state        <= state_d;
      beat         <= beat_d;
      frame        <= frame_d;
      m_axis_valid <= valid_d;
      m_axis_data  <= data_d;
      m_axis_last  <= last_d;
      busy         <= busy_d;
      done         <= done_d;
      beat_cnt     <= cnt_d;
    end
  end

  // Next-state and next-output logic; every output is registered above.
  always_comb begin
    state_d = state;
    beat_d  = beat;
    frame_d = frame;
    valid_d = m_axis_valid;
    data_d  = m_axis_data;
    last_d  = m_axis_last;
    busy_d  = busy;
    done_d  = 1'b0;
    cnt_d   = beat_cnt;
    case (state)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        last_d  = 1'b0;
        if (start) begin
          state_d = STREAM;
          data_d  = SEED_V;
          beat_d  = '0;
          frame_d = '0;
          cnt_d   = '0;
          last_d  = LAST_INIT;
          busy_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      STREAM: begin
        valid_d = 1'b1;
        if (m_axis_valid && m_axis_ready) begin
          cnt_d = beat_cnt + 32'd1;
          if (beat != BEAT_LAST) begin
            beat_d = beat + BEAT_W'(1);
            data_d = step(m_axis_data);
            last_d = (BEAT_W'(beat + BEAT_W'(1)) == BEAT_LAST);
          end else if (frame != FRAME_LAST) begin
            frame_d = frame + FRAME_W'(1);
            beat_d  = '0;
            data_d  = (FRAME_RELOAD != 0) ? SEED_V : step(m_axis_data);
            last_d  = LAST_INIT;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
